// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: pin synchronizers, clock glitch filter, frame FSM
// with timeout, and a small scancode FIFO whose head is registered onto ps2_read.
module ps2_receiver #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        ps2_read_ack,
  output logic [31:0] ps2_read
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]    clk_sync, data_sync;
  logic          clk_s, data_s;
  logic          filt, fall;
  logic [FW-1:0] fcnt;

  state_t        state, state_n;
  logic [2:0]    bitcnt, bitcnt_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          push_req, push_n;
  logic          perr_set, perr_set_n;
  logic          ferr_set, ferr_set_n;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_n;
  logic [CW-1:0] count, count_n;
  logic          ovf, perr, ferr, ovf_n, perr_n, ferr_n;
  logic          full, empty, pop, wr_en, ovf_set;
  logic [7:0]    head_n;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      filt      <= 1'b1;
      fcnt      <= '0;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      fall      <= filt & ~clk_s & (fcnt == FW'(FILTER_LEN - 1));
      if (clk_s == filt) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt <= clk_s;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      bitcnt   <= '0;
      shift    <= '0;
      par      <= 1'b0;
      tcnt     <= '0;
      push_req <= 1'b0;
      perr_set <= 1'b0;
      ferr_set <= 1'b0;
    end else begin
      state    <= state_n;
      bitcnt   <= bitcnt_n;
      shift    <= shift_n;
      par      <= par_n;
      tcnt     <= tcnt_n;
      push_req <= push_n;
      perr_set <= perr_set_n;
      ferr_set <= ferr_set_n;
    end
  end

  always_comb begin
    state_n    = state;
    bitcnt_n   = bitcnt;
    shift_n    = shift;
    par_n      = par;
    push_n     = 1'b0;
    perr_set_n = 1'b0;
    ferr_set_n = 1'b0;
    tcnt_n     = (state == S_IDLE || fall) ? '0 : tcnt + TW'(1);
    if (fall) begin
      case (state)
        S_IDLE: if (!data_s) begin
          state_n  = S_DATA;
          bitcnt_n = '0;
        end
        S_DATA: begin
          shift_n  = {data_s, shift[7:1]};
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_n = S_PARITY;
        end
        S_PARITY: begin
          par_n   = data_s;
          state_n = S_STOP;
        end
        S_STOP: begin
          if (!data_s)            ferr_set_n = 1'b1;
          else if (^{shift, par}) push_n     = 1'b1;
          else                    perr_set_n = 1'b1;
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end else if (state != S_IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n = S_IDLE;
    end
  end

  // shift is stable after the stop edge, so it doubles as the push data.
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign pop     = ps2_read_ack & ~empty;
  assign wr_en   = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;
  assign count_n = count + CW'(wr_en) - CW'(pop);
  assign rd_n    = rd_ptr + PW'(pop);
  assign ovf_n   = ovf_set  | (ovf  & ~ps2_read_ack);
  assign perr_n  = perr_set | (perr & ~ps2_read_ack);
  assign ferr_n  = ferr_set | (ferr & ~ps2_read_ack);

  // Next head bypasses the write when it lands on the slot being written.
  always_comb begin
    head_n = '0;
    if (count_n != '0) begin
      if (wr_en && rd_n == wr_ptr) head_n = shift;
      else                         head_n = mem[rd_n];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      ps2_read <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr   <= rd_n;
      count    <= count_n;
      ovf      <= ovf_n;
      perr     <= perr_n;
      ferr     <= ferr_n;
      ps2_read <= {20'b0, ferr_n, perr_n, ovf_n, (count_n != '0), head_n};
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: bit-banged PS/2 frames with hand-computed
// ps2_read expectations, checked by immediate assertions.
module tb_ps2_receiver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ps2_clk;
  logic        ps2_data;
  logic        ps2_read_ack;
  logic [31:0] ps2_read;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  ps2_receiver #(
    .FILTER_LEN(4),
    .TIMEOUT_CYCLES(100),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .ps2_read_ack(ps2_read_ack),
    .ps2_read(ps2_read)
  );

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] exp);
    vectors++;
    assert (ps2_read === exp) else begin
      miscompares++;
      $error("FAIL %s: ps2_read=%h expected %h", tag, ps2_read, exp);
    end
  endtask

  // One PS/2 bit: data set while clock high, 20-cycle low phase, optional 1-cycle glitch.
  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    clks(10);
    ps2_clk = 1'b0;
    clks(20);
    ps2_clk = 1'b1;
    if (glitch) begin
      clks(4);
      ps2_clk = 1'b0;
      clks(1);
      ps2_clk = 1'b1;
      clks(5);
    end else begin
      clks(10);
    end
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par,
                            input logic stop, input bit glitch);
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(code[i], glitch);
    ps2_bit((~^code) ^ bad_par, glitch);
    ps2_bit(stop, glitch);
    ps2_data = 1'b1;
    clks(5);
  endtask

  task automatic ack();
    ps2_read_ack = 1'b1;
    clks(1);
    ps2_read_ack = 1'b0;
    clks(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    ps2_read_ack = 1'b0;
    reset_n = 1'b0;
    clks(5);
    check("reset", 32'h0000_0000);
    reset_n = 1'b1;
    clks(5);
    check("idle", 32'h0000_0000);

    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("good_1c", 32'h0000_011C);
    clks(50);
    check("good_1c_held", 32'h0000_011C);
    ack();
    check("good_1c_ack", 32'h0000_0000);

    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check("parity_err", 32'h0000_0400);
    ack();
    check("parity_err_ack", 32'h0000_0000);

    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    check("frame_err", 32'h0000_0800);
    ack();
    check("frame_err_ack", 32'h0000_0000);

    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
    check("overflow", 32'h0000_0301);
    ack();
    check("pop_2", 32'h0000_0102);
    ack();
    check("pop_3", 32'h0000_0103);
    ack();
    check("pop_4", 32'h0000_0104);
    ack();
    check("drained", 32'h0000_0000);
    ack();
    check("ack_empty", 32'h0000_0000);

    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    clks(200);
    check("timeout_quiet", 32'h0000_0000);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    check("after_timeout", 32'h0000_0129);
    ack();
    check("after_timeout_ack", 32'h0000_0000);

    ps2_data = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clks(5);
      ps2_clk = 1'b0;
      clks(1);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    clks(10);
    check("idle_glitch", 32'h0000_0000);
    send_frame(8'h33, 1'b0, 1'b1, 1'b1);
    check("glitch_frame", 32'h0000_0133);
    ack();
    check("glitch_frame_ack", 32'h0000_0000);

    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    check("pre_reset", 32'h0000_0111);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b1, 1'b0);
    reset_n = 1'b0;
    clks(3);
    check("mid_reset", 32'h0000_0000);
    ps2_data = 1'b1;
    reset_n = 1'b1;
    clks(5);
    check("post_reset", 32'h0000_0000);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    check("after_reset", 32'h0000_015A);
    ack();
    check("after_reset_ack", 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
